// File: rtl/vga_pkg.sv
// Shared timing constants, delay-line flag bundle and width helper
// for the parametrised VGA timing controller.
package vga_pkg;

   // 640x480@60 defaults
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;

   // small test mode
   localparam int TST_H_ACTIVE = 20;
   localparam int TST_H_FRONT  = 1;
   localparam int TST_H_SYNC   = 2;
   localparam int TST_H_BACK   = 3;
   localparam int TST_V_ACTIVE = 30;
   localparam int TST_V_FRONT  = 1;
   localparam int TST_V_SYNC   = 2;
   localparam int TST_V_BACK   = 3;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } flags_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus visible and
// sync region decodes, advanced by an external increment strobe.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         in_active,
   output logic         in_sync
);

   localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

   localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
   localparam logic [W:0]   ACT_END = (W + 1)'(ACTIVE);
   localparam logic [W:0]   SYN_BEG = (W + 1)'(ACTIVE + FRONT);
   localparam logic [W:0]   SYN_END = (W + 1)'(ACTIVE + FRONT + SYNC);

   logic [W:0] cnt_ext;

   assign cnt_ext   = {1'b0, count};
   assign wrap      = inc && (count == LAST);
   assign in_active = cnt_ext < ACT_END;
   assign in_sync   = (cnt_ext >= SYN_BEG) && (cnt_ext < SYN_END);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA timing: pixel-rate divider, h/v counters, and a
// flag delay line aligning sync/blanking with late-arriving colour.
module vga_timing_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK,
   parameter int CLK_DIV  = 4,
   parameter int PIPE     = 1,
   parameter int COLOR_W  = 8,
   parameter int CNT_W    = 10,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [3*COLOR_W-1:0]   color_in,
   output logic                   pix_en,
   output logic                   active,
   output logic [CNT_W-1:0]       active_x,
   output logic [CNT_W-1:0]       active_y,
   output logic                   screenend,
   output logic [15:0]            frame_cnt,
   output logic                   hsync,
   output logic                   vsync,
   output logic [COLOR_W-1:0]     red,
   output logic [COLOR_W-1:0]     green,
   output logic [COLOR_W-1:0]     blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   if (CNT_W < clog2(H_TOTAL) || CNT_W < clog2(V_TOTAL)) begin : g_bad_cnt_w
      $error("CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   if (CLK_DIV < 1 || PIPE < 1) begin : g_bad_div_pipe
      $error("CLK_DIV and PIPE must be at least 1");
   end

   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_nxt;

   assign div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

   // pix_en is a flop tracking div==CLK_DIV-1, so it is low in reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div    <= '0;
         pix_en <= 1'b0;
      end else begin
         div    <= div_nxt;
         pix_en <= (div_nxt == DIV_LAST);
      end
   end

   logic h_wrap, h_act, h_sync;
   logic v_wrap, v_act, v_sync;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK),
      .W      (CNT_W)
   ) u_h (
      .clk       (clk),
      .rst       (rst),
      .inc       (pix_en),
      .count     (active_x),
      .wrap      (h_wrap),
      .in_active (h_act),
      .in_sync   (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK),
      .W      (CNT_W)
   ) u_v (
      .clk       (clk),
      .rst       (rst),
      .inc       (h_wrap),
      .count     (active_y),
      .wrap      (v_wrap),
      .in_active (v_act),
      .in_sync   (v_sync)
   );

   assign active    = h_act && v_act;
   assign screenend = v_wrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
      end else if (v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end

   flags_t cur;
   flags_t dly;

   assign cur = '{de: active, hs: h_sync, vs: v_sync};

   // PIPE-1 stages so the flags meet the colour of the same pixel
   if (PIPE > 1) begin : g_dly
      flags_t pipe_q [PIPE-1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 0; i < PIPE - 1; i++) pipe_q[i] <= '0;
         end else if (pix_en) begin
            pipe_q[0] <= cur;
            for (int i = 1; i < PIPE - 1; i++) pipe_q[i] <= pipe_q[i-1];
         end
      end

      assign dly = pipe_q[PIPE-2];
   end else begin : g_no_dly
      assign dly = cur;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hsync <= !H_POL;
         vsync <= !V_POL;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else if (pix_en) begin
         hsync <= dly.hs ? H_POL : !H_POL;
         vsync <= dly.vs ? V_POL : !V_POL;
         red   <= dly.de ? color_in[3*COLOR_W-1 -: COLOR_W] : '0;
         green <= dly.de ? color_in[2*COLOR_W-1 -: COLOR_W] : '0;
         blue  <= dly.de ? color_in[COLOR_W-1:0] : '0;
      end
   end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
Parametrised successor to the team's fixed-format VGA controller. Generates horizontal/vertical timing from per-axis parameters and derives a pixel-rate enable from the system clock by an integer divider. Presents pixel coordinates to the upstream pixel source ahead of time, then samples its colour a programmable number of pixel periods later so source pipeline latency is absorbed. Drives hsync/vsync and RGB to the DAC/pins; sync polarity and colour width are configurable.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels); H_TOTAL = sum of the four H params
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines); V_TOTAL = sum of the four V params
CLK_DIV, 4, system clocks per pixel (>=1)
PIPE, 1, pixel periods from coordinate presentation to colour sampling (>=1)
COLOR_W, 8, bits per colour channel
CNT_W, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
H_POL, 0, hsync asserted level (0 = active-low)
V_POL, 0, vsync asserted level

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
color_in  in  3*COLOR_W  {R,G,B} for the pixel requested PIPE-1 pixel periods earlier
pix_en  out  1  one-clk pixel strobe (tied high when CLK_DIV=1)
active  out  1  current request coordinate is inside the visible area
active_x  out  CNT_W  current horizontal count (request side)
active_y  out  CNT_W  current vertical count (request side)
screenend  out  1  one-clk pulse at the end of the last pixel of a frame
frame_cnt  out  16  completed frames, wraps at 0xFFFF->0
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
red, green, blue  out  COLOR_W each  colour out; zero outside the visible area

Behaviour:
- Reset (synchronous, rst high at posedge): divider, h/v counters, active_x, active_y, frame_cnt, the delay line and RGB go to 0. active goes to 1, since (0,0) is visible. hsync=!H_POL and vsync=!V_POL. pix_en and screenend go to 0. Reset mid-frame aborts the frame immediately; no partial-frame bookkeeping.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div==CLK_DIV-1), registered-equivalent, one clk wide. The first pix_en after reset is at clock CLK_DIV-1.
- Counters advance only on pix_en. h wraps at H_TOTAL-1 to 0; v increments on the h wrap and wraps at V_TOTAL-1 to 0.
- active = (h<H_ACTIVE)&&(v<V_ACTIVE). Both active and the coordinates are registered and held stable for the full pixel period.
- Sync regions:
  - hs raw = H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC.
  - vs raw = V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC. vs is line-granular and changes at the same pix_en as the h wrap.
- Delay line: {active, hs, vs} is shifted through PIPE-1 stages, advancing only on pix_en.
- Output registers load on pix_en and hold otherwise:
  - hsync = hs_d ? H_POL : !H_POL; vsync likewise with V_POL.
  - RGB = de_d ? color_in : 0.
  - With PIPE=1 the output loads directly from the current-period flags and color_in.
- Latency: a pixel's hsync/vsync/RGB appear exactly PIPE pixel periods after its coordinates appear.
- screenend / frame_cnt: screenend pulses on the clock where pix_en && h==H_TOTAL-1 && v==V_TOTAL-1, referenced to the request side. frame_cnt increments on that same clock.
- No backpressure. color_in is sampled only on pix_en edges and may change freely otherwise.
- CLK_DIV=1: pix_en stays high from the first clock after reset release.

Decomposition:
- Shared package/include vga_pkg:
  - default 640x480@60 timing constants;
  - a small test mode (20/1/2/3, 30/1/2/3);
  - a clog2 function for CNT_W checks.
- One sub-module, vga_axis_counter, instantiated twice (h, v). Parameters: ACTIVE/FRONT/SYNC/BACK/W. Ports: clk, rst, inc, count, wrap, in_active, in_sync.
- The divider, delay line and output registers stay in the top.

Test Plan:
All tests use H=20/1/2/3 (H_TOTAL=26), V=30/1/2/3 (V_TOTAL=36), CLK_DIV=4, PIPE=1, COLOR_W=8 unless stated.
- Reset release -> active=1, x=y=0, hsync=vsync=1, RGB=0; first pix_en at clock 3; x=1 after clock 3.
- Free run -> pix_en every 4 clocks; hsync low for exactly 8 clks starting when x reaches 21; line period 104 clks; vsync low for 2 lines starting at y=31.
- color_in=x replicated on R,G,B -> red sequence 0..19 on the output, delayed one pixel from coordinates; 0 during blanking; red=19 never appears when active was low.
- Run 2 frames -> screenend pulses exactly 2 times, 3744 clks apart; frame_cnt=2.
- PIPE=3, color_in taken from a 2-stage external registered copy of x -> output red matches the pixel index; hsync edge shifted by 2 pixel periods vs PIPE=1.
- CLK_DIV=1 and rst asserted mid-line at x=10, y=5 -> next clock all outputs at reset values; x=0 and y=0 resume counting one step per clock.
